fetch_queue: RTL and testbench

//   Instruction buffer between fetch and decode. Captures {pc, insnbits} each cycle

---
 rtl/fetch_queue.sv | 88 ++++++++
 tb/tb_fetch_queue.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: in-order {pc, insnbits} FIFO with
// ROB flush, full back-pressure and a sticky halt once an HLT word is accepted.
module fetch_queue #(
    parameter int DEPTH      = 8,
    parameter int PC_WIDTH   = 64,
    parameter int INSN_WIDTH = 32,
    parameter logic [INSN_WIDTH-1:0] INSNBITS_HLT = 32'hD440_0000
) (
    input  logic                        in_clk,
    input  logic                        in_rst,
    input  logic                        in_rob_mispredict,
    input  logic                        in_f_done,
    input  logic [PC_WIDTH-1:0]         in_f_pc,
    input  logic [INSN_WIDTH-1:0]       in_f_insnbits,
    output logic                        out_f_stall,
    input  logic                        in_d_ready,
    output logic                        out_d_valid,
    output logic [PC_WIDTH-1:0]         out_d_pc,
    output logic [INSN_WIDTH-1:0]       out_d_insnbits,
    output logic [$clog2(DEPTH):0]      out_count,
    output logic                        out_halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic               full;
    logic               enq, deq;

    logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];
    logic [INSN_WIDTH-1:0] insn_mem [DEPTH];

    // Handshakes: fetch is accepted when in_f_done & ~out_f_stall; decode consumes
    // the head when out_d_valid & in_d_ready. A flush or reset cancels both.
    assign full        = (count_q == CNT_W'(DEPTH));
    assign out_f_stall = full | (state_q == ST_HALTED);
    assign out_d_valid = (count_q != '0);
    assign enq = in_f_done & ~out_f_stall & ~in_rob_mispredict & ~in_rst;
    assign deq = out_d_valid & in_d_ready & ~in_rob_mispredict & ~in_rst;

    assign out_d_pc       = out_d_valid ? pc_mem[head_q]   : '0;
    assign out_d_insnbits = out_d_valid ? insn_mem[head_q] : '0;
    assign out_count      = count_q;
    assign out_halted     = (state_q == ST_HALTED);

    always_comb begin
        state_d = state_q;
        if (in_rob_mispredict) begin
            state_d = ST_RUN;
        end else if (enq && (in_f_insnbits == INSNBITS_HLT)) begin
            state_d = ST_HALTED;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst || in_rob_mispredict) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) tail_q <= tail_q + PTR_W'(1);
            if (deq) head_q <= head_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Storage is deliberately not reset; only the pointers define what is live.
    always_ff @(posedge in_clk) begin
        if (enq) begin
            pc_mem[tail_q]   <= in_f_pc;
            insn_mem[tail_q] <= in_f_insnbits;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by random traffic, all
// compared cycle by cycle against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam logic [31:0] HLT = 32'hD440_0000;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_rob_mispredict;
    logic        in_f_done;
    logic [63:0] in_f_pc;
    logic [31:0] in_f_insnbits;
    logic        out_f_stall;
    logic        in_d_ready;
    logic        out_d_valid;
    logic [63:0] out_d_pc;
    logic [31:0] out_d_insnbits;
    logic [3:0]  out_count;
    logic        out_halted;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of {pc, insn} plus a halted flag.
    logic [95:0] exp_q[$];
    bit          m_halted = 0;

    fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(64), .INSN_WIDTH(32), .INSNBITS_HLT(HLT)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_rob_mispredict(in_rob_mispredict),
        .in_f_done(in_f_done), .in_f_pc(in_f_pc), .in_f_insnbits(in_f_insnbits),
        .out_f_stall(out_f_stall), .in_d_ready(in_d_ready), .out_d_valid(out_d_valid),
        .out_d_pc(out_d_pc), .out_d_insnbits(out_d_insnbits), .out_count(out_count),
        .out_halted(out_halted)
    );

    always #5 in_clk = ~in_clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [95:0] h;
        bit m_stall;
        m_stall = (exp_q.size() == DEPTH) || m_halted;
        h = (exp_q.size() != 0) ? exp_q[0] : 96'h0;
        check_eq({tag, "_count"}, 128'(out_count), 128'(exp_q.size()));
        check_eq({tag, "_valid"}, 128'(out_d_valid), 128'(exp_q.size() != 0));
        check_eq({tag, "_stall"}, 128'(out_f_stall), 128'(m_stall));
        check_eq({tag, "_pc"}, 128'(out_d_pc), 128'(h[95:32]));
        check_eq({tag, "_insn"}, 128'(out_d_insnbits), 128'(h[31:0]));
        check_eq({tag, "_halted"}, 128'(out_halted), 128'(m_halted));
        check_eq({tag, "_bound"}, 128'(out_count <= DEPTH), 128'(1));
    endtask

    // Drive one cycle, check the registered outputs, advance the model and the clock.
    task automatic cycle(input string tag, input bit done, input logic [63:0] pc,
                         input logic [31:0] insn, input bit rdy, input bit mis);
        bit m_stall, do_enq, do_deq;
        in_f_done = done; in_f_pc = pc; in_f_insnbits = insn;
        in_d_ready = rdy; in_rob_mispredict = mis; in_rst = 1'b0;
        #1;
        check_outputs(tag);
        m_stall = (exp_q.size() == DEPTH) || m_halted;
        do_enq = done && !m_stall && !mis;
        do_deq = (exp_q.size() != 0) && rdy && !mis;
        if (mis) begin
            exp_q.delete();
            m_halted = 0;
        end else begin
            if (do_deq) void'(exp_q.pop_front());
            if (do_enq) begin
                exp_q.push_back({pc, insn});
                if (insn == HLT) m_halted = 1;
            end
        end
        @(posedge in_clk); #1;
    endtask

    task automatic do_reset(input int cycles);
        in_rst = 1'b1; in_rob_mispredict = 1'b0; in_f_done = 1'b1;
        in_f_pc = 64'h1234; in_f_insnbits = 32'h1; in_d_ready = 1'b1;
        repeat (cycles) @(posedge in_clk);
        #1;
        in_rst = 1'b0; in_f_done = 1'b0; in_d_ready = 1'b0;
        exp_q.delete();
        m_halted = 0;
    endtask

    initial begin
        logic [63:0] rpc;
        logic [31:0] rinsn;
        // T1 reset
        do_reset(2);
        check_outputs("t1");

        // T2 ordering
        for (int i = 0; i < 3; i++) cycle("t2_fill", 1, 64'h40_0000 + 64'(4 * i), 32'hA000_0000 + 32'(i), 0, 0);
        for (int i = 0; i < 4; i++) cycle("t2_drain", 0, 64'h0, 32'h0, 1, 0);

        // T3 full, dropped 9th word, accepted one edge after a dequeue
        for (int i = 0; i < DEPTH; i++) cycle("t3_fill", 1, 64'h1000 + 64'(4 * i), 32'hB000_0000 + 32'(i), 0, 0);
        check_eq("t3_full_stall", 128'(out_f_stall), 128'(1));
        cycle("t3_drop", 1, 64'h2000, 32'hBBBB_0009, 0, 0);
        cycle("t3_deq", 1, 64'h2000, 32'hBBBB_0009, 1, 0);
        check_eq("t3_count7", 128'(out_count), 128'(7));
        cycle("t3_accept", 1, 64'h2000, 32'hBBBB_0009, 0, 0);
        check_eq("t3_count8", 128'(out_count), 128'(8));
        for (int i = 0; i < DEPTH + 1; i++) cycle("t3_drain", 0, 64'h0, 32'h0, 1, 0);

        // T4 simultaneous enq+deq across the wrap point
        for (int i = 0; i < 3; i++) cycle("t4_fill", 1, 64'h3000 + 64'(4 * i), 32'hC000_0000 + 32'(i), 0, 0);
        for (int i = 0; i < 5; i++) cycle("t4_both", 1, 64'h3100 + 64'(4 * i), 32'hC100_0000 + 32'(i), 1, 0);
        check_eq("t4_count3", 128'(out_count), 128'(3));
        for (int i = 0; i < 4; i++) cycle("t4_drain", 0, 64'h0, 32'h0, 1, 0);

        // T5 flush with traffic active
        for (int i = 0; i < 5; i++) cycle("t5_fill", 1, 64'h5000 + 64'(4 * i), 32'hD000_0000 + 32'(i), 0, 0);
        cycle("t5_flush", 1, 64'h5FFF, 32'hDEAD_BEEF, 1, 1);
        check_eq("t5_count0", 128'(out_count), 128'(0));
        check_eq("t5_valid0", 128'(out_d_valid), 128'(0));
        for (int i = 0; i < 3; i++) cycle("t5_refill", 1, 64'h6000 + 64'(4 * i), 32'hE000_0000 + 32'(i), 0, 0);
        for (int i = 0; i < 4; i++) cycle("t5_drain", 0, 64'h0, 32'h0, 1, 0);

        // T6 halt
        cycle("t6_a", 1, 64'h7000, 32'h8B00_0000, 0, 0);
        cycle("t6_hlt", 1, 64'h7004, HLT, 0, 0);
        check_eq("t6_stall", 128'(out_f_stall), 128'(1));
        for (int i = 0; i < 4; i++) cycle("t6_drain", 1, 64'h7100, 32'h1111_1111, 1, 0);
        check_eq("t6_empty_stall", 128'(out_f_stall), 128'(1));
        cycle("t6_flush", 0, 64'h0, 32'h0, 0, 1);
        check_eq("t6_run", 128'(out_f_stall), 128'(0));
        cycle("t6_after", 1, 64'h7200, 32'h2222_2222, 0, 0);
        cycle("t6_after2", 0, 64'h0, 32'h0, 1, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rpc = {$urandom, $urandom};
            rinsn = ($urandom_range(0, 39) == 0) ? HLT : $urandom;
            if ($urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(1, 2));
                check_outputs("rnd_rst");
            end else begin
                cycle("rnd", $urandom_range(0, 3) != 0, rpc, rinsn,
                      $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
